// File: rtl/i2c_txn_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_txn_arbiter
//
// Shares one I2C byte master between NUM_REQ requesters. A round-robin pick
// grants one requester, latches its direction and write byte, and sends one
// start command to the master. The block then waits for the master to finish
// or for a timeout, and returns the read byte and status to the winner.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   req        per-requester request level, held until done
//   req_rw     per-requester direction (1 read, 0 write)
//   req_wdata  per-requester write byte, requester i at [8i+7:8i]
//   gnt        one-hot grant, held for the whole transaction
//   done       one-cycle completion pulse to the granted requester
//   err        one-cycle pulse with done when the transaction was aborted
//   rdata      read byte, valid from a done pulse until the next one
//   m_start    one-cycle start command to the master
//   m_rw       latched direction to the master
//   m_wdata    latched write byte to the master
//   m_busy     master is in a transaction
//   m_done     master completion pulse
//   m_rdata    master read byte, sampled on m_done
//   state      FSM state, for debug
//
// All outputs are registered. The action a state takes shows up on the
// outputs in the following cycle, so m_start is seen in the first WAIT_BUSY
// cycle and done is seen the cycle after m_done.
//
// state      | meaning
// IDLE       | pick the next requester and latch its rw/wdata
// GRANT      | one setup cycle so m_rw/m_wdata settle before the start
// ISSUE      | send the start command, clear the timer
// WAIT_BUSY  | wait for the master to go busy (or finish very quickly)
// WAIT_DONE  | wait for m_done or the transaction timeout
// RELEASE    | drop the grant, advance the pointer, wait for the master idle
// ---------------------------------------------------------------------------
module i2c_txn_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int TIMEOUT_CYCLES   = 1024,
    parameter int BUSY_WAIT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic                   err,
    output logic [7:0]             rdata,
    output logic                   m_start,
    output logic                   m_rw,
    output logic [7:0]             m_wdata,
    input  logic                   m_busy,
    input  logic                   m_done,
    input  logic [7:0]             m_rdata,
    output logic [2:0]             state
);

    localparam int IW   = $clog2(NUM_REQ);
    localparam int TMAX = (TIMEOUT_CYCLES > BUSY_WAIT_CYCLES) ? TIMEOUT_CYCLES : BUSY_WAIT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] BUSY_LIM = TW'(BUSY_WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GRANT     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_RELEASE   = 3'd5
    } state_t;

    state_t               st, st_nxt;
    logic [IW-1:0]        ptr, ptr_nxt;
    logic [IW-1:0]        gnt_idx, gnt_idx_nxt;
    logic [NUM_REQ-1:0]   gnt_nxt, done_nxt;
    logic                 err_nxt, m_start_nxt, m_rw_nxt;
    logic [7:0]           rdata_nxt, m_wdata_nxt;
    logic [TW-1:0]        timer, timer_nxt;

    logic                 pick_found;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 pick_rw;
    logic [7:0]           pick_wdata;

    assign state = st;

    // Round-robin pick: the first set request at or after ptr, with wrap.
    // The outer loop walks the rotation distance, so the nearest one wins.
    always_comb begin
        pick_found = 1'b0;
        pick_oh    = '0;
        pick_idx   = '0;
        pick_rw    = 1'b0;
        pick_wdata = 8'h00;
        for (int off = 0; off < NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pick_found && req[i] && (((int'(ptr) + off) % NUM_REQ) == i)) begin
                    pick_found = 1'b1;
                    pick_oh[i] = 1'b1;
                    pick_idx   = IW'(i);
                    pick_rw    = req_rw[i];
                    pick_wdata = req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        st_nxt      = st;
        ptr_nxt     = ptr;
        gnt_idx_nxt = gnt_idx;
        gnt_nxt     = gnt;
        done_nxt    = '0;
        err_nxt     = 1'b0;
        rdata_nxt   = rdata;
        m_start_nxt = 1'b0;
        m_rw_nxt    = m_rw;
        m_wdata_nxt = m_wdata;
        timer_nxt   = (timer == '1) ? timer : timer + TW'(1);

        case (st)
            S_IDLE: begin
                if (pick_found) begin
                    gnt_nxt     = pick_oh;
                    gnt_idx_nxt = pick_idx;
                    m_rw_nxt    = pick_rw;
                    m_wdata_nxt = pick_wdata;
                    st_nxt      = S_GRANT;
                end
            end
            S_GRANT: begin
                st_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                m_start_nxt = 1'b1;
                timer_nxt   = '0;
                st_nxt      = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // A master fast enough to finish before we see busy still
                // counts as a normal completion.
                if (m_done) begin
                    done_nxt = gnt;
                    if (m_rw) rdata_nxt = m_rdata;
                    st_nxt = S_RELEASE;
                end else if (m_busy) begin
                    st_nxt = S_WAIT_DONE;
                end else if (timer >= BUSY_LIM) begin
                    done_nxt  = gnt;
                    err_nxt   = 1'b1;
                    rdata_nxt = 8'h00;
                    st_nxt    = S_RELEASE;
                end
            end
            S_WAIT_DONE: begin
                // m_done is checked first so it beats a same-cycle timeout.
                if (m_done) begin
                    done_nxt = gnt;
                    if (m_rw) rdata_nxt = m_rdata;
                    st_nxt = S_RELEASE;
                end else if (timer >= TO_LIM) begin
                    done_nxt  = gnt;
                    err_nxt   = 1'b1;
                    rdata_nxt = 8'h00;
                    st_nxt    = S_RELEASE;
                end
            end
            S_RELEASE: begin
                gnt_nxt = '0;
                ptr_nxt = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
                if (!m_busy) st_nxt = S_IDLE;
            end
            default: begin
                gnt_nxt = '0;
                st_nxt  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st      <= S_IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            gnt     <= '0;
            done    <= '0;
            err     <= 1'b0;
            rdata   <= 8'h00;
            m_start <= 1'b0;
            m_rw    <= 1'b0;
            m_wdata <= 8'h00;
            timer   <= '0;
        end else begin
            st      <= st_nxt;
            ptr     <= ptr_nxt;
            gnt_idx <= gnt_idx_nxt;
            gnt     <= gnt_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            rdata   <= rdata_nxt;
            m_start <= m_start_nxt;
            m_rw    <= m_rw_nxt;
            m_wdata <= m_wdata_nxt;
            timer   <= timer_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_txn_arbiter
//
// Directed bench for i2c_txn_arbiter with a small behavioural I2C master.
// Runs with a short timeout (32) and busy wait (16) so abort paths stay
// quick. Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_i2c_txn_arbiter;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_GRANT     = 3'd1;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_RELEASE   = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req_rw;
    logic [31:0] req_wdata;
    logic [3:0]  gnt, done;
    logic        err, m_start, m_rw;
    logic [7:0]  rdata, m_wdata, m_rdata;
    logic        m_busy, m_done;
    logic [2:0]  state;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_starts = 0;

    // master model controls
    int         cfg_busy_dly = 0;   // 0 = never goes busy
    int         cfg_done_dly = 0;   // 0 = never completes
    logic [7:0] cfg_rdata = 8'h00;
    bit         kill = 1'b0;
    bit         active = 1'b0;
    int         mcnt = 0;

    i2c_txn_arbiter #(
        .NUM_REQ(4), .TIMEOUT_CYCLES(32), .BUSY_WAIT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .m_start(m_start), .m_rw(m_rw), .m_wdata(m_wdata),
        .m_busy(m_busy), .m_done(m_done), .m_rdata(m_rdata), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Master: mcnt = k on the falling edge k cycles after m_start was seen.
    always @(negedge clk) begin
        if (!rst || kill) begin
            active = 1'b0;
            m_busy = 1'b0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (active) begin
                mcnt++;
                if (cfg_busy_dly != 0 && mcnt == cfg_busy_dly) m_busy = 1'b1;
                if (cfg_done_dly != 0 && mcnt == cfg_done_dly) begin
                    m_done  = 1'b1;
                    m_rdata = cfg_rdata;
                    m_busy  = 1'b0;
                    active  = 1'b0;
                end
            end
            if (m_start) begin
                n_starts++;
                active = 1'b1;
                mcnt   = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    end

    // what: 0 = state GRANT, 1 = m_start, 2 = any done
    task automatic wait_for(input int what, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit && !ok; k++) begin
            @(negedge clk);
            if ((what == 0 && state == S_GRANT) || (what == 1 && m_start) ||
                (what == 2 && done != 4'b0000))
                ok = 1'b1;
        end
    endtask

    task automatic run_txn(input string tag, input logic [3:0] rq, input logic [3:0] rw,
                           input logic [3:0] exp_gnt, input int bdly, input int ddly,
                           input logic [7:0] mrd, input int exp_lat, input logic exp_err,
                           input logic [7:0] exp_rd);
        int t_req, t_st;
        bit ok;
        cfg_busy_dly = bdly;
        cfg_done_dly = ddly;
        cfg_rdata    = mrd;
        req    = rq;
        req_rw = rw;
        t_req  = cyc;
        wait_for(0, 6, ok);
        chk({tag, "_grant_seen"}, 32'(ok), 32'd1);
        chk({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        chk({tag, "_gnt_lat"}, 32'(cyc - t_req), 32'd1);
        wait_for(1, 6, ok);
        chk({tag, "_start_seen"}, 32'(ok), 32'd1);
        chk({tag, "_start_lat"}, 32'(cyc - t_req), 32'd3);
        t_st = cyc;
        wait_for(2, exp_lat + 4, ok);
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
        chk({tag, "_done_lat"}, 32'(cyc - t_st), 32'(exp_lat));
        chk({tag, "_done"}, 32'(done), 32'(exp_gnt));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
        req = 4'b0000;
        @(negedge clk);
        chk({tag, "_gnt_drop"}, 32'(gnt), 32'd0);
        chk({tag, "_pulse_end"}, 32'({done, err}), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  s0;
        bit  ok;
        logic [3:0] e;
        rst = 1'b1;
        req = 4'b0000;
        req_rw = 4'b0000;
        req_wdata = {8'h44, 8'hC7, 8'h33, 8'hA5};
        m_busy = 1'b0;
        m_done = 1'b0;
        m_rdata = 8'h00;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_outs", 32'({gnt, done, err, m_start, m_rw}), 32'd0);
        chk("rst_bytes", 32'({rdata, m_wdata}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // single read from requester 2
        s0 = n_starts;
        run_txn("read", 4'b0100, 4'b0100, 4'b0100, 3, 10, 8'h3C, 11, 1'b0, 8'h3C);
        chk("read_m_rw", 32'(m_rw), 32'd1);
        chk("read_m_wdata", 32'(m_wdata), 32'h33 ^ 32'hF4);
        chk("read_starts", 32'(n_starts - s0), 32'd1);

        // single write from requester 0; rdata must keep the previous read
        s0 = n_starts;
        run_txn("write", 4'b0001, 4'b0000, 4'b0001, 3, 20, 8'h77, 21, 1'b0, 8'h3C);
        chk("write_m_rw", 32'(m_rw), 32'd0);
        chk("write_m_wdata", 32'(m_wdata), 32'hA5);
        chk("write_starts", 32'(n_starts - s0), 32'd1);

        // fairness after a reset: pointer restarts at 0
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cfg_busy_dly = 2;
        cfg_done_dly = 5;
        cfg_rdata    = 8'h5A;
        req    = 4'b1111;
        req_rw = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            e = 4'b0001 << (k % 4);
            wait_for(0, 20, ok);
            chk("rr_grant_seen", 32'(ok), 32'd1);
            chk("rr_gnt", 32'(gnt), 32'(e));
            wait_for(2, 30, ok);
            chk("rr_done_seen", 32'(ok), 32'd1);
            chk("rr_done", 32'(done), 32'(e));
            chk("rr_rdata", 32'(rdata), 32'h5A);
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // timeout: master stays busy forever, abort 32 cycles after m_start
        run_txn("timeout", 4'b0010, 4'b0010, 4'b0010, 3, 0, 8'h00, 32, 1'b1, 8'h00);
        chk("timeout_hold", 32'(state), 32'(S_RELEASE));
        kill = 1'b1;
        repeat (3) @(negedge clk);
        kill = 1'b0;
        chk("timeout_idle", 32'(state), 32'(S_IDLE));

        // m_done on the exact timeout cycle wins
        run_txn("race", 4'b0100, 4'b0100, 4'b0100, 3, 31, 8'hC3, 32, 1'b0, 8'hC3);

        // master never goes busy: abort 16 cycles after m_start
        run_txn("busy_abort", 4'b1000, 4'b0000, 4'b1000, 0, 0, 8'h00, 16, 1'b1, 8'h00);

        // reset during WAIT_DONE, checked before any clock edge
        cfg_busy_dly = 3;
        cfg_done_dly = 0;
        req    = 4'b0001;
        req_rw = 4'b0001;
        wait_for(1, 8, ok);
        chk("mid_start_seen", 32'(ok), 32'd1);
        repeat (6) @(negedge clk);
        chk("mid_wait_done", 32'(state), 32'(S_WAIT_DONE));
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state), 32'(S_IDLE));
        chk("mid_rst_outs", 32'({gnt, done, err, m_start, m_rw}), 32'd0);
        chk("mid_rst_wdata", 32'(m_wdata), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        chk("mid_no_done", 32'({done, err}), 32'd0);
        rst = 1'b1;
        run_txn("post_rst", 4'b1000, 4'b0000, 4'b1000, 2, 6, 8'h11, 7, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares the single I2C master between NUM_REQ requesters, one full byte transaction at a time.
- Arbitrates round-robin and latches the winner's rw/data.
- Issues a one-cycle start command to the master, waits for its completion or a timeout, then returns read data and status to the winner.
- Sits between the system-side requesters and the master's control/data bus; the master keeps ownership of sclk/sda.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, clk cycles allowed from m_start to m_done before abort.
- BUSY_WAIT_CYCLES, 64, clk cycles allowed from m_start to m_busy high before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester transaction request, level, held until done
- req_rw  in  NUM_REQ  per-requester direction, 1 read, 0 write
- req_wdata  in  8*NUM_REQ  per-requester write byte; requester i uses bits [8i+7:8i]
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse coincident with done when the transaction timed out
- rdata  out  8  read byte, valid from the done pulse until the next done pulse
- m_start  out  1  one-cycle start command to the master
- m_rw  out  1  latched direction to the master
- m_wdata  out  8  latched write byte to the master
- m_busy  in  1  master is in a transaction (any non-idle state)
- m_done  in  1  one-cycle pulse when the master returns to idle after stop
- m_rdata  in  8  master read byte, sampled on m_done
- state  out  3  FSM state, debug

Behaviour:
- Reset is asynchronous, active-low, and applies from any state:
  - gnt=0, done=0, err=0, rdata=8'h00, m_start=0, m_rw=0, m_wdata=8'h00.
  - state=IDLE, round-robin pointer=0, timers cleared.
  - A transaction in flight is abandoned with no done pulse.
- State encoding: IDLE=0, GRANT=1, ISSUE=2, WAIT_BUSY=3, WAIT_DONE=4, RELEASE=5.
- IDLE:
  - If req!=0, select the first set req at or after the pointer, scanning upward with wrap.
  - Register gnt (one-hot), m_rw=req_rw[i], m_wdata=req_wdata[i]; go to GRANT.
- GRANT: one-cycle setup so m_rw/m_wdata are stable before the start command; go to ISSUE.
- ISSUE: m_start=1 for exactly this cycle; clear timers; go to WAIT_BUSY.
- WAIT_BUSY:
  - m_busy=1 -> WAIT_DONE.
  - If the busy timer reaches BUSY_WAIT_CYCLES-1 -> abort.
  - m_done seen here (very short transaction) is treated as completion.
- WAIT_DONE:
  - m_done=1 -> rdata<=m_rdata when m_rw=1; rdata is unchanged for writes. Pulse done[i]; go to RELEASE.
  - If the timeout timer (counts from ISSUE) reaches TIMEOUT_CYCLES-1 without m_done -> abort.
  - If m_done and the timeout land in the same cycle, m_done wins and no err is raised.
- Abort: pulse done[i] and err together, rdata<=8'h00, go to RELEASE.
- RELEASE:
  - gnt<=0; pointer<=(i+1) mod NUM_REQ.
  - Wait until m_busy=0, then go to IDLE.
  - A requester that keeps req high is re-eligible only after the requesters ahead of it in rotation.
- Timers: width clog2(max(TIMEOUT_CYCLES,BUSY_WAIT_CYCLES)); saturate, never wrap.
- Requester drop: if req[i] falls while granted, the transaction still completes and done[i] still pulses. Inputs are sampled only in IDLE.
- Latency: req rising in IDLE -> gnt after 1 clk; m_start 2 clk after gnt; done 1 clk after m_done.
- Exactly one gnt bit, or none, is set at any time; done/err never pulse outside WAIT_BUSY/WAIT_DONE exits.

Test Plan:
- Single write: req=4'b0001, req_rw=0, wdata0=8'hA5; master model busy after 3 clk, m_done after 200 clk -> gnt=0001, m_wdata=A5, m_rw=0, one m_start pulse, done[0] pulse, err=0.
- Single read: req[2]=1, rw=1, m_rdata=8'h3C on m_done -> rdata=3C on done[2]; gnt drops the next cycle.
- Fairness: req=4'b1111 held continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3; never two gnt bits set.
- Timeout: master never pulses m_done, TIMEOUT_CYCLES=32 -> done[i] and err pulse together 32 clk after m_start, rdata=00, FSM back in IDLE once m_busy=0.
- Race: m_done asserted on the exact timeout cycle -> done pulses, err=0, rdata=m_rdata.
- Reset mid-transaction: assert rst low during WAIT_DONE -> all outputs reset immediately without a clk edge; after release, req=4'b1000 is granted to requester 3, with the pointer restarted at 0.
